datapath_legv8_param: RTL
=========================

Name: datapath_legv8_param

Overview:
Parametrised next-generation LEGv8 datapath: register file, ALU, B-operand mux and tristate bus drivers, plus a program counter and a latched status register. The register-file write port is fed from the shared data bus, so ALU results, register B and external memory share one write-back path. It sits between the control unit and the memory/IO bus, and exposes visualization taps for the board display.

Parameters:
DATA_W, 64, datapath and register width (≥8, power of two)
ADDR_W, 32, address bus and PC width (≤ DATA_W)
NUM_REGS, 32, register count (power of two); index NUM_REGS-1 is the zero register (XZR)
VIS_W, 16, width of each visualization output (≤ DATA_W)

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
data  inout  DATA_W  shared tristate data bus; also the register-file write data
address  out(tri)  ADDR_W  tristate address bus
constant  in  DATA_W  immediate operand
DA, SA, SB  in  clog2(NUM_REGS)  destination, A-source and B-source register indices
W  in  1  register write enable
FS  in  5  ALU function select
C0  in  1  ALU carry-in
Bsel  in  1  0: B operand = register B; 1: B operand = constant
SL  in  1  status-latch enable
PS  in  2  PC op: 00 hold, 01 +4, 10 load from data[ADDR_W-1:0], 11 PC + 4 + constant[ADDR_W-1:0]
EN_ALU, EN_B  in  1  drive F / register B onto data
EN_ADDR_ALU, EN_PC  in  1  drive F[ADDR_W-1:0] / PC onto address
status  out  4  latched {V,C,N,Z}
status_raw  out  4  combinational flags of the current F
pc  out  ADDR_W  current PC
r0..r7  out  VIS_W  low VIS_W bits of registers 0..7

Behaviour:
- Register file: two async reads (SA→A, SB→B). Reading XZR returns 0.
- Write at posedge clock when W=1 and DA≠NUM_REGS-1, with D = data (resolved bus value). Writes to XZR are ignored.
- Reset clears all registers, PC = 0 and status = 0 on the clock edge where reset=1. Reset has priority over W, SL and PS. An operation in progress when reset is asserted is discarded.
- ALU is combinational. Operand Ai = FS[1] ? ~A : A; Bi = FS[0] ? ~B : B. FS[4:2] selects the result:
  - 000 Ai&Bi
  - 001 Ai|Bi
  - 010 Ai+Bi+C0
  - 011 Ai^Bi
  - 100 A << B[log2(DATA_W)-1:0]
  - 101 A >> B (logical)
  - 11x F = 0
- Flags:
  - Z = (F==0)
  - N = F[DATA_W-1]
  - C = carry-out of the adder (0 for non-add ops)
  - V = signed overflow of the adder (0 for non-add ops)
- status_raw always reflects the current F. status loads status_raw at posedge when SL=1, otherwise holds.
- PC updates at posedge per PS. Arithmetic is modulo 2^ADDR_W (wrap-around). PS=10 with nothing driving data loads X; the control unit must guarantee a driver.
- Tristates:
  - data = F when EN_ALU; data = B when EN_B.
  - address = F[ADDR_W-1:0] when EN_ADDR_ALU; address = PC when EN_PC.
  - All drivers disabled → Z.
  - EN_ALU and EN_B together, or EN_ADDR_ALU and EN_PC together, is illegal. Under `ifndef SYNTHESIS`, the simulation model prints an error message for either condition.
- Same-cycle read/write to one register: reads return the old value until the edge (no bypass).
- Latency: combinational A/B/F to buses; 1 cycle to register, status and PC state.

Optional Feature:
DP_ALU_PIPE_EN
- Defined:
  - F and its flags are captured in a result register on every posedge (reset to 0).
  - EN_ALU, EN_ADDR_ALU, status_raw and the SL latch all use the registered values, adding 1 cycle of latency.
- Undefined: purely combinational ALU path as described above.

Test Plan:
1. Reset, then write: reset=1 for one edge → pc=0, status=0, r0..r7=0. Then drive data=0x1234 externally, W=1, DA=3 → r3=0x1234 after the next edge.
2. Add with overflow: r1=0x7FFF_FFFF_FFFF_FFFF, constant=1, Bsel=1, FS=01000, C0=0, EN_ALU=1, W=1, DA=2, SL=1 → r2=0x8000_0000_0000_0000, status={V=1,C=0,N=1,Z=0}.
3. Subtract to zero: r4=5, r5=5, FS=01001, C0=1 → F=0, status_raw={0,1,0,1}. With SL=0, the latched status is unchanged.
4. XZR: DA=31, W=1, data=0xFF → a subsequent read with SA=31 returns 0 (F with FS=00100 is 0).
5. PC: PS=01 for 3 edges → pc=12. Then PS=11 with constant=0xFFFF_FFF0 → pc=0 (wrap). Then PS=10 with data=0x40 driven → pc=0x40. EN_PC=1 → address=0x40.
6. Tristate and pipeline: all enables 0 → data and address are Z. With DP_ALU_PIPE_EN defined, F appears on data exactly one edge after the operands are applied.

Source files
------------

// File: rtl/datapath_legv8_param.sv
// datapath_legv8_param: parametrised LEGv8 datapath with a register file, ALU,
// B-operand mux, tristate data/address drivers, program counter and latched status.
// Optional macro DP_ALU_PIPE_EN: registers the ALU result and flags, adding one
// cycle between operands and their use on the buses, status_raw and the status latch.

module datapath_legv8_param_chk (
  input logic clock,
  input logic en_alu,
  input logic en_b,
  input logic en_addr_alu,
  input logic en_pc
);
  // Report illegal simultaneous bus drivers
  always @(posedge clock) begin
    if (en_alu && en_b) begin
      $error("datapath_legv8_param: data bus contention, EN_ALU and EN_B both asserted");
    end
    if (en_addr_alu && en_pc) begin
      $error("datapath_legv8_param: address bus contention, EN_ADDR_ALU and EN_PC both asserted");
    end
  end
endmodule

module datapath_legv8_param #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int VIS_W    = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  inout  wire  [DATA_W-1:0]           data,
  output wire  [ADDR_W-1:0]           address,
  input  logic [DATA_W-1:0]           constant,
  input  logic [$clog2(NUM_REGS)-1:0] DA,
  input  logic [$clog2(NUM_REGS)-1:0] SA,
  input  logic [$clog2(NUM_REGS)-1:0] SB,
  input  logic                        W,
  input  logic [4:0]                  FS,
  input  logic                        C0,
  input  logic                        Bsel,
  input  logic                        SL,
  input  logic [1:0]                  PS,
  input  logic                        EN_ALU,
  input  logic                        EN_B,
  input  logic                        EN_ADDR_ALU,
  input  logic                        EN_PC,
  output logic [3:0]                  status,
  output logic [3:0]                  status_raw,
  output logic [ADDR_W-1:0]           pc,
  output logic [VIS_W-1:0]            r0,
  output logic [VIS_W-1:0]            r1,
  output logic [VIS_W-1:0]            r2,
  output logic [VIS_W-1:0]            r3,
  output logic [VIS_W-1:0]            r4,
  output logic [VIS_W-1:0]            r5,
  output logic [VIS_W-1:0]            r6,
  output logic [VIS_W-1:0]            r7
);
  localparam int RIDX_W = $clog2(NUM_REGS);
  localparam int SH_W   = $clog2(DATA_W);
  localparam logic [RIDX_W-1:0] XZR = RIDX_W'(NUM_REGS - 1);

  logic [DATA_W-1:0] regs_r [NUM_REGS];
  logic [DATA_W-1:0] a_s;
  logic [DATA_W-1:0] b_s;
  logic [DATA_W-1:0] b_op_s;
  logic [DATA_W-1:0] ai_s;
  logic [DATA_W-1:0] bi_s;
  logic [DATA_W:0]   sum_s;
  logic [DATA_W-1:0] f_s;
  logic              is_add_s;
  logic [3:0]        flags_s;
  logic [DATA_W-1:0] f_out_s;
  logic [3:0]        flags_out_s;

  // Signed overflow of an addition from the operand and sum sign bits
  function automatic logic add_overflow(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  // Asynchronous register reads; the zero register always reads as 0
  always_comb begin
    a_s = '0;
    b_s = '0;
    if (SA == XZR) a_s = '0;
    else           a_s = regs_r[SA];
    if (SB == XZR) b_s = '0;
    else           b_s = regs_r[SB];
  end

  // ALU: operand inversion, function select and flag generation
  always_comb begin
    b_op_s   = Bsel ? constant : b_s;
    ai_s     = FS[1] ? ~a_s : a_s;
    bi_s     = FS[0] ? ~b_op_s : b_op_s;
    sum_s    = {1'b0, ai_s} + {1'b0, bi_s} + {{DATA_W{1'b0}}, C0};
    f_s      = '0;
    is_add_s = 1'b0;
    case (FS[4:2])
      3'b000:  f_s = ai_s & bi_s;
      3'b001:  f_s = ai_s | bi_s;
      3'b010: begin
        f_s      = sum_s[DATA_W-1:0];
        is_add_s = 1'b1;
      end
      3'b011:  f_s = ai_s ^ bi_s;
      3'b100:  f_s = a_s << b_op_s[SH_W-1:0];
      3'b101:  f_s = a_s >> b_op_s[SH_W-1:0];
      default: f_s = '0;
    endcase
    flags_s = {is_add_s & add_overflow(ai_s[DATA_W-1], bi_s[DATA_W-1], sum_s[DATA_W-1]),
               is_add_s & sum_s[DATA_W],
               f_s[DATA_W-1],
               (f_s == '0)};
  end

`ifdef DP_ALU_PIPE_EN
  logic [DATA_W-1:0] f_r;
  logic [3:0]        flags_r;

  // Capture the ALU result and its flags on every edge
  always_ff @(posedge clock) begin
    if (reset) begin
      f_r     <= '0;
      flags_r <= '0;
    end else begin
      f_r     <= f_s;
      flags_r <= flags_s;
    end
  end

  assign f_out_s     = f_r;
  assign flags_out_s = flags_r;
`else
  assign f_out_s     = f_s;
  assign flags_out_s = flags_s;
`endif

  assign status_raw = flags_out_s;

  // Tristate drivers; the control unit never enables two drivers on one bus
  assign data    = EN_ALU ? f_out_s : (EN_B ? b_s : {DATA_W{1'bz}});
  assign address = EN_ADDR_ALU ? f_out_s[ADDR_W-1:0] : (EN_PC ? pc : {ADDR_W{1'bz}});

  // Register file write-back from the resolved data bus
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= '0;
    end else if (W && (DA != XZR)) begin
      regs_r[DA] <= data;
    end
  end

  // Status latch
  always_ff @(posedge clock) begin
    if (reset)   status <= 4'b0000;
    else if (SL) status <= flags_out_s;
  end

  // Program counter update, modulo 2^ADDR_W
  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= '0;
    end else begin
      case (PS)
        2'b00:   pc <= pc;
        2'b01:   pc <= pc + ADDR_W'(4);
        2'b10:   pc <= data[ADDR_W-1:0];
        2'b11:   pc <= pc + ADDR_W'(4) + constant[ADDR_W-1:0];
        default: pc <= pc;
      endcase
    end
  end

  assign r0 = regs_r[0][VIS_W-1:0];
  assign r1 = regs_r[1][VIS_W-1:0];
  assign r2 = regs_r[2][VIS_W-1:0];
  assign r3 = regs_r[3][VIS_W-1:0];
  assign r4 = regs_r[4][VIS_W-1:0];
  assign r5 = regs_r[5][VIS_W-1:0];
  assign r6 = regs_r[6][VIS_W-1:0];
  assign r7 = regs_r[7][VIS_W-1:0];

`ifndef SYNTHESIS
  datapath_legv8_param_chk u_chk (
    .clock       (clock),
    .en_alu      (EN_ALU),
    .en_b        (EN_B),
    .en_addr_alu (EN_ADDR_ALU),
    .en_pc       (EN_PC)
  );
`endif

endmodule
